// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer
//   Takes shaded pixels (x, y, rgb444) from the shading stage, drops the ones
//   that fall outside the framebuffer, buffers the rest in a small FIFO and
//   drains it into a framebuffer BRAM write port whenever that port allows.
//   It also counts the writes in each frame and pulses frame_done_out when a
//   full frame's worth of pixels has been written.
//
// Ports
//   clk_in          single clock, rising edge
//   rst_in          synchronous reset, active low
//   x_in, y_in      pixel coordinate
//   r_in,g_in,b_in  pixel colour, 4 bits per channel
//   rgb_valid_in    pixel fields valid this cycle
//   pixel_ready_out FIFO can take a pixel (held low while in reset)
//   wr_enable_in    framebuffer port can take a write; low stalls the drain
//   frame_start_in  one-cycle pulse, new frame
//   bram_addr_out   write address, y*FB_WIDTH + x
//   bram_data_out   write data {r,g,b}
//   bram_we_out     write strobe
//   frame_done_out  one-cycle pulse on the last write of a frame
//   overflow_out    sticky, a pixel was dropped because the FIFO was full
module pixel_fb_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 180,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic        rgb_valid_in,
  output logic        pixel_ready_out,
  input  logic        wr_enable_in,
  input  logic        frame_start_in,
  output logic [16:0] bram_addr_out,
  output logic [11:0] bram_data_out,
  output logic        bram_we_out,
  output logic        frame_done_out,
  output logic        overflow_out
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [10:0]     X_LIM     = 11'(FB_WIDTH);
  localparam logic [9:0]      Y_LIM     = 10'(FB_HEIGHT);
  localparam logic [15:0]     PIX_TOTAL = 16'(FB_WIDTH * FB_HEIGHT);
  localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]  CNT_ONE   = 1;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } fb_entry_t;

  fb_entry_t        mem [FIFO_DEPTH];
  fb_entry_t        push_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic             in_range, accept, push, pop, drop;
  logic [16:0]      pix_addr;

  logic [15:0]      wr_cnt, wr_cnt_inc, wr_cnt_nxt;
  logic             done_nxt;

  // Ready comes from the pre-edge count only, so a pop on the same edge
  // never frees a slot for the pixel being offered.
  assign pixel_ready_out = rst_in && (count != CNT_FULL);

  assign in_range = (x_in < X_LIM) && (y_in < Y_LIM);
  assign accept   = rgb_valid_in && pixel_ready_out;
  assign push     = accept && in_range;
  // Any pixel offered while full is lost, in range or not.
  assign drop     = rst_in && rgb_valid_in && !pixel_ready_out;
  assign pop      = rst_in && (count != '0) && wr_enable_in;

  // Full 17-bit product: 179*320 + 319 = 57599 fits without wrap.
  assign pix_addr        = 17'(y_in) * 17'(FB_WIDTH) + 17'(x_in);
  assign push_entry.addr = pix_addr;
  assign push_entry.data = {r_in, g_in, b_in};

  assign wr_cnt_inc = wr_cnt + 16'd1;

  // Frame write counter. frame_start wins over a completing frame, and a pop
  // on the frame_start edge already belongs to the new frame.
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    done_nxt   = 1'b0;
    if (frame_start_in) begin
      wr_cnt_nxt = pop ? 16'd1 : 16'd0;
    end else if (pop) begin
      if (wr_cnt_inc == PIX_TOTAL) begin
        wr_cnt_nxt = '0;
        done_nxt   = 1'b1;
      end else begin
        wr_cnt_nxt = wr_cnt_inc;
      end
    end
  end

  // Storage has no reset; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      wr_cnt         <= '0;
      bram_we_out    <= 1'b0;
      bram_addr_out  <= '0;
      bram_data_out  <= '0;
      frame_done_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      bram_we_out <= pop;
      if (pop) begin
        bram_addr_out <= mem[rd_ptr].addr;
        bram_data_out <= mem[rd_ptr].data;
      end

      wr_cnt         <= wr_cnt_nxt;
      frame_done_out <= done_nxt;

      // A drop in the frame_start cycle is still reported.
      if (drop)                overflow_out <= 1'b1;
      else if (frame_start_in) overflow_out <= 1'b0;
    end
  end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 Parameter FB_WIDTH, 320, framebuffer width in pixels; x_in values >= FB_WIDTH are out of range.
REQ-002 Parameter FB_HEIGHT, 180, framebuffer height in pixels; y_in values >= FB_HEIGHT are out of range.
REQ-003 Parameter FIFO_DEPTH, 4, pixel buffer depth, power of two.
REQ-004 Port clk_in  input  1  the single clock; all logic is on its rising edge.
REQ-005 Port rst_in  input  1  reset, synchronous and active-low.
REQ-006 Ports x_in 11, y_in 10, r_in 4, g_in 4, b_in 4, all inputs, carry the pixel coordinate and colour from the RGB shading stage.
REQ-007 Port rgb_valid_in  input  1  pixel fields are valid this cycle.
REQ-008 Port pixel_ready_out  output  1  high when the FIFO is not full.
REQ-009 Port wr_enable_in  input  1  high when the framebuffer port may accept writes; low means stall.
REQ-010 Port frame_start_in  input  1  one-cycle pulse that starts a new frame.
REQ-011 Port bram_addr_out  output  17  framebuffer write address.
REQ-012 Port bram_data_out  output  12  framebuffer write data, {r,g,b}.
REQ-013 Port bram_we_out  output  1  write strobe.
REQ-014 Port frame_done_out  output  1  one-cycle pulse when the frame is complete.
REQ-015 Port overflow_out  output  1  sticky flag set when a pixel is dropped because the FIFO was full.

Function
REQ-016 Accept condition: rgb_valid_in && pixel_ready_out on a rising edge.
REQ-017 In-range pixels (x_in < FB_WIDTH && y_in < FB_HEIGHT) are pushed into the FIFO.
REQ-018 Address arithmetic: y_in*FB_WIDTH + x_in, computed at full 17-bit width with no truncation for the default parameters, and stored in the FIFO with the data.
REQ-019 Out-of-range pixels are accepted and discarded: no push, no count, no overflow.
REQ-020 rgb_valid_in while the FIFO is full: pixel dropped and overflow_out set to 1 on the next edge.
REQ-021 A pop on the same edge does not rescue a pixel offered while full, because pixel_ready_out is derived from the pre-edge count.
REQ-022 Pop condition: FIFO non-empty && wr_enable_in; pops at most one entry per edge.
REQ-023 Output register: on each pop, bram_addr_out and bram_data_out load the head entry and bram_we_out is 1.
REQ-024 No pop: bram_we_out is 0 and bram_addr_out/bram_data_out hold their previous values.
REQ-025 Latency: a pixel accepted at edge k into an empty FIFO, with wr_enable_in high, produces bram_we_out=1 after edge k+1 (two-cycle latency).
REQ-026 Simultaneous push and pop: both occur, count is unchanged and ordering is preserved; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 Write counter: 16-bit, increments on each pop; when it reaches FB_WIDTH*FB_HEIGHT, frame_done_out pulses for one cycle on that same edge and the counter clears to 0.
REQ-028 frame_start_in effects: clears the write counter and overflow_out; FIFO contents are retained.
REQ-029 frame_start_in and a pop on the same edge: the counter loads 1 (the pop is counted in the new frame).
REQ-030 frame_start_in overrides the frame_done_out pulse on the same edge.

Reset
REQ-031 When rst_in is low at a rising edge: FIFO empties, pointers and count go to 0, write counter goes to 0, bram_we_out=0, bram_addr_out=0, bram_data_out=0, frame_done_out=0, overflow_out=0.
REQ-032 pixel_ready_out is 1 after the reset edge.
REQ-033 Reset mid-operation discards all buffered pixels; no write strobe is issued from pre-reset data.
REQ-034 While rst_in is low, inputs are ignored and pixel_ready_out is 0.

Verification
REQ-035 Single pixel x=100, y=50, rgb=F/0/0, wr_enable_in=1 -> two cycles later bram_we_out=1, addr=16100, data=12'hF00, for exactly one cycle.
REQ-036 Out-of-range: x=320, y=10, valid -> no bram_we_out, no overflow; then x=319, y=179 -> addr=57599.
REQ-037 Backpressure: wr_enable_in=0, six consecutive valid pixels -> first 4 buffered, pixel_ready_out=0, overflow_out=1; raise wr_enable_in -> exactly 4 writes in order.
REQ-038 Full with push and pop on the same edge: FIFO full, wr_enable_in=1, one new valid pixel -> that pixel is dropped, overflow_out=1, one write occurs.
REQ-039 Frame completion: FB_WIDTH=4, FB_HEIGHT=2, 8 in-range pixels -> frame_done_out pulses on the edge of the 8th write, then the counter returns to 0.
REQ-040 Reset mid-burst: rst_in low for one edge with 3 pixels buffered -> bram_we_out=0 thereafter, pixel_ready_out=1 after reset is released, overflow_out=0.
